// File: rtl/bch_syndrome_collect.sv
// Collects the final odd-syndrome set of each BCH codeword into a one-deep output slot.
// Define BCH_SYN_ZERO_SKIP_EN to drop all-zero sets and pulse `clean` instead of presenting them.
module bch_syndrome_collect #(
    parameter int M           = 8,
    parameter int T           = 4,
    parameter int DATA_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         ce,
    input  logic [T*M-1:0] syn_in,
    output logic [T*M-1:0] syn_out,
    output logic         err_present,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         abort,
    output logic         overrun
`ifdef BCH_SYN_ZERO_SKIP_EN
    ,
    output logic         clean
`endif
);

    localparam int CW = $clog2(DATA_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, CAPTURE} state_t;

    state_t              state_q;
    logic [CW-1:0]       count_q;
    logic [T*M-1:0]      syn_q;
    logic                err_q;
    logic                valid_q;
    logic                abort_q;
    logic                ovr_q;
    logic                clean_q;

    logic [T-1:0]        lane_nz;
    logic                syn_nz;
    logic                slot_free;
    logic                skip_d;

    for (genvar i = 0; i < T; i++) begin : g_lane
        assign lane_nz[i] = |syn_in[i*M +: M];
    end

    assign syn_nz    = |lane_nz;
    // An accept in the capture cycle frees the slot for the incoming set with no bubble.
    assign slot_free = !valid_q || out_ready;

`ifdef BCH_SYN_ZERO_SKIP_EN
    assign skip_d = !syn_nz;
    assign clean  = clean_q;
`else
    assign skip_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            syn_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            ovr_q   <= 1'b0;
            clean_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            clean_q <= 1'b0;
            if (valid_q && out_ready)
                valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && ce) begin
                        state_q <= ACCUM;
                        count_q <= CW'(1);
                    end
                end
                ACCUM: begin
                    if (ce) begin
                        if (start) begin
                            count_q <= CW'(1);
                            abort_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CW'(1);
                            if (count_q == LAST)
                                state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (skip_d) begin
                        clean_q <= 1'b1;
                    end else if (slot_free) begin
                        syn_q   <= syn_in;
                        err_q   <= syn_nz;
                        valid_q <= 1'b1;
                    end else begin
                        ovr_q   <= 1'b1;
                    end
                    // A start here chains the next codeword without an abort.
                    if (start && ce) begin
                        state_q <= ACCUM;
                        count_q <= CW'(1);
                    end else begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign syn_out     = syn_q;
    assign err_present = err_q;
    assign out_valid   = valid_q;
    assign busy        = (state_q != IDLE);
    assign abort       = abort_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_bch_syndrome_collect.sv
// Randomized and directed checks of bch_syndrome_collect (M=4, T=2, DATA_CYCLES=15) against a behavioural model.
module tb_bch_syndrome_collect;

    localparam int M  = 4;
    localparam int T  = 2;
    localparam int DC = 15;
    localparam int W  = M * T;
`ifdef BCH_SYN_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, ce, out_ready;
    logic [W-1:0] syn_in;
    logic [W-1:0] syn_out;
    logic         err_present, out_valid, busy, abort, overrun;
    logic         clean_w;

    bch_syndrome_collect #(.M(M), .T(T), .DATA_CYCLES(DC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .ce         (ce),
        .syn_in     (syn_in),
        .syn_out    (syn_out),
        .err_present(err_present),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .abort      (abort),
        .overrun    (overrun)
`ifdef BCH_SYN_ZERO_SKIP_EN
        ,
        .clean      (clean_w)
`endif
    );
`ifndef BCH_SYN_ZERO_SKIP_EN
    assign clean_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: phase 0 = no codeword, 1 = counting ce cycles, 2 = the one capture cycle.
    int           m_ph, m_ce;
    bit           m_valid, m_err, m_abort, m_ovr, m_clean;
    logic [W-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_ce = 0;
        m_valid = 0; m_err = 0; m_abort = 0; m_ovr = 0; m_clean = 0;
        m_data = '0;
    endtask

    task automatic model_next(input bit st, input bit c, input logic [W-1:0] syn, input bit rdy);
        bit n_valid;
        n_valid = m_valid && !rdy;
        m_abort = 0;
        m_clean = 0;
        if (m_ph == 2) begin
            if (ZS && syn == 0) m_clean = 1;
            else if (!m_valid || rdy) begin
                m_data = syn; m_err = (syn != 0); n_valid = 1;
            end else m_ovr = 1;
            if (st && c) begin m_ph = 1; m_ce = 1; end
            else begin m_ph = 0; m_ce = 0; end
        end else if (m_ph == 1) begin
            if (c && st) begin m_ce = 1; m_abort = 1; end
            else if (c) begin
                m_ce++;
                if (m_ce == DC) m_ph = 2;
            end
        end else if (st && c) begin
            m_ph = 1; m_ce = 1;
        end
        m_valid = n_valid;
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("syn_out", 32'(syn_out), 32'(m_data));
        chk("err_present", 32'(err_present), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("abort", 32'(abort), 32'(m_abort));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (ZS) chk("clean", 32'(clean_w), 32'(m_clean));
    endtask

    task automatic cyc(input bit st, input bit c, input logic [W-1:0] syn, input bit rdy);
        start = st; ce = c; syn_in = syn; out_ready = rdy;
        model_next(st, c, syn, rdy);
        @(negedge clk);
        compare_all();
    endtask

    // Optional start, 14 accumulating ce cycles, then the capture cycle.
    task automatic cw(input bit do_start, input logic [W-1:0] cap_syn, input bit rdy_acc,
                      input bit rdy_cap, input bit chain);
        if (do_start) cyc(1, 1, W'($urandom), rdy_acc);
        for (int i = 0; i < DC - 1; i++) cyc(0, 1, W'($urandom), rdy_acc);
        cyc(chain, chain, cap_syn, rdy_cap);
    endtask

    task automatic async_reset();
        @(negedge clk);
        reset_n = 0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_syn", 32'(syn_out), 0);
        chk("rst_err", 32'(err_present), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_abort", 32'(abort), 0);
        chk("rst_ovr", 32'(overrun), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        start = 0; ce = 0; out_ready = 0; syn_in = '0;
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset_n = 1;

        cw(1, 8'h3A, 1, 1, 0);
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_syn", 32'(syn_out), 32'h3A);
        chk("basic_err", 32'(err_present), 1);
        cyc(0, 0, 0, 1);
        chk("basic_valid_one", 32'(out_valid), 0);

        cw(1, 8'h5C, 0, 0, 1);
        chk("simul_first", 32'(syn_out), 32'h5C);
        cw(0, 8'h71, 0, 1, 0);
        chk("simul_valid", 32'(out_valid), 1);
        chk("simul_syn", 32'(syn_out), 32'h71);
        chk("simul_ovr", 32'(overrun), 0);
        cyc(0, 0, 0, 1);

        cw(1, 8'hA1, 0, 0, 1);
        cw(0, 8'hB2, 0, 0, 0);
        chk("bp_syn", 32'(syn_out), 32'hA1);
        chk("bp_ovr", 32'(overrun), 1);
        chk("bp_valid", 32'(out_valid), 1);
        cyc(0, 0, 0, 1);

        cw(1, 8'h00, 1, 1, 0);
        if (ZS) begin
            chk("zero_clean", 32'(clean_w), 1);
            chk("zero_valid", 32'(out_valid), 0);
        end else begin
            chk("zero_valid", 32'(out_valid), 1);
            chk("zero_err", 32'(err_present), 0);
        end
        cyc(0, 0, 0, 1);

        cyc(1, 1, 8'h11, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 8'h22, 1);
        cyc(1, 1, 8'h33, 1);
        chk("restart_abort", 32'(abort), 1);
        cw(0, 8'h4D, 1, 1, 0);
        chk("restart_valid", 32'(out_valid), 1);
        chk("restart_syn", 32'(syn_out), 32'h4D);

        cyc(1, 1, 8'h55, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'h66, 0);
        async_reset();
        compare_all();
        cyc(1, 1, 8'h12, 1);
        for (int i = 0; i < DC - 1; i++) begin
            cyc(0, 0, 8'h34, 1);
            cyc(0, 1, 8'h56, 1);
        end
        chk("gap_busy", 32'(busy), 1);
        cyc(0, 0, 8'h96, 1);
        chk("gap_valid", 32'(out_valid), 1);
        chk("gap_syn", 32'(syn_out), 32'h96);

        for (int n = 0; n < 6000; n++) begin
            bit           st, c, rdy;
            logic [W-1:0] syn;
            if ($urandom_range(0, 699) == 0) begin
                async_reset();
                compare_all();
            end else begin
                c   = ($urandom_range(0, 3) != 0);
                st  = (m_ph == 1) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
                rdy = ((n / 300) % 2 == 0) ? ($urandom_range(0, 1) == 0)
                                           : ($urandom_range(0, 9) == 0);
                syn = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 255));
                cyc(st, c, syn, rdy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
